// File: rtl/haze_pkg.sv
// Shared definitions for the haze-removal frame scheduler: state encoding and
// default image geometry.
package haze_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PASS1    = 3'd1;
  localparam logic [2:0] ST_ALE_WAIT = 3'd2;
  localparam logic [2:0] ST_PASS2    = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam int unsigned IMG_WIDTH_DEF  = 512;
  localparam int unsigned IMG_HEIGHT_DEF = 512;
  localparam int unsigned PIX_N_DEF      = IMG_WIDTH_DEF * IMG_HEIGHT_DEF;
  localparam int unsigned CNT_W_DEF      = 19;

endpackage

// File: rtl/haze_beat_counter.sv
// Saturating beat counter: counts up to LIMIT and holds there, with a
// terminal-count flag on the last beat (cnt == LIMIT-1).
module haze_beat_counter
  import haze_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned LIMIT = PIX_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_FULL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CNT_LAST);

endmodule

// File: rtl/haze_pass_scheduler.sv
// Two-pass frame sequencer: streams a frame to the ALE, waits for its result,
// then streams the same frame to TE/SRSC and drains the output.
module haze_pass_scheduler
  import haze_pkg::*;
#(
  parameter int unsigned IMG_WIDTH     = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT    = IMG_HEIGHT_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned DRAIN_TIMEOUT = 4096
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic enable,
  input  logic S_AXIS_TVALID,
  input  logic S_AXIS_TLAST,
  output logic S_AXIS_TREADY,
  output logic dp_valid,
  output logic pass_sel,
  output logic ale_clear,
  output logic ale_last,
  input  logic ale_done,
  input  logic out_valid,
  input  logic M_AXIS_TREADY,
  output logic M_AXIS_TLAST,
  output logic frame_done,
  output logic busy,
  output logic err_tlast,
  output logic err_timeout,
  input  logic err_clear
);

  localparam int unsigned      N        = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);
  localparam logic [CNT_W-1:0] N_LAST   = CNT_W'(N - 1);
  localparam int unsigned      TMR_W    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_tlast_q, err_tlast_d;
  logic             err_timeout_q, err_timeout_d;
  logic             set_tlast, set_timeout;

  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic             in_tc, out_tc, out_full;
  logic             in_beat, out_beat, counting;

  assign S_AXIS_TREADY = (state_q == ST_PASS1) || (state_q == ST_PASS2);
  assign in_beat       = S_AXIS_TVALID && S_AXIS_TREADY;
  assign counting      = (state_q == ST_PASS2) || (state_q == ST_DRAIN);
  assign out_full      = (out_cnt == N_CNT);
  // Output beats outside PASS2/DRAIN, or beyond N, are ignored.
  assign out_beat      = out_valid && M_AXIS_TREADY && counting && !out_full;

  haze_beat_counter #(.CNT_W(CNT_W), .LIMIT(N)) u_in_cnt (
    .clk (ACLK),
    .rst (ARESET),
    .inc (in_beat),
    .clr (in_beat && in_tc),
    .cnt (in_cnt),
    .tc  (in_tc)
  );

  haze_beat_counter #(.CNT_W(CNT_W), .LIMIT(N)) u_out_cnt (
    .clk (ACLK),
    .rst (ARESET),
    .inc (out_beat),
    .clr (!counting),
    .cnt (out_cnt),
    .tc  (out_tc)
  );

  always_comb begin
    state_d     = state_q;
    tmr_d       = '0;
    set_tlast   = 1'b0;
    set_timeout = 1'b0;
    // TLAST must coincide exactly with beat N; the count stays authoritative.
    if (in_beat) begin
      set_tlast = S_AXIS_TLAST ? (in_cnt < N_LAST) : in_tc;
    end
    case (state_q)
      ST_IDLE:     if (enable) state_d = ST_PASS1;
      ST_PASS1:    if (in_beat && in_tc) state_d = ST_ALE_WAIT;
      ST_ALE_WAIT: if (ale_done) state_d = ST_PASS2;
      ST_PASS2:    if (in_beat && in_tc) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (out_full || (out_beat && out_tc)) begin
          state_d = ST_DONE;
        end else if (!out_beat) begin
          if (tmr_q == TMR_LAST) begin
            set_timeout = 1'b1;
            state_d     = ST_DONE;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      ST_DONE:     state_d = enable ? ST_PASS1 : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    err_tlast_d   = err_clear ? 1'b0 : (err_tlast_q || set_tlast);
    err_timeout_d = err_clear ? 1'b0 : (err_timeout_q || set_timeout);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      err_tlast_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      err_tlast_q   <= err_tlast_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign dp_valid     = in_beat;
  assign pass_sel     = counting;
  // Gated by reset so no clear pulse escapes while reset is held.
  assign ale_clear    = enable && !ARESET && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign ale_last     = (state_q == ST_PASS1) && in_beat && in_tc;
  assign M_AXIS_TLAST = out_beat && out_tc;
  assign frame_done   = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign err_tlast    = err_tlast_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: doc/haze_pass_scheduler.md
Name: haze_pass_scheduler

Overview:
- Frame-level sequencer for the two-pass haze-removal pipeline.
- Pass 1 streams a full frame into the atmospheric light estimator (ALE). The scheduler then waits for the ALE result.
- Pass 2 streams the same frame into transmission estimation (TE) and scene recovery (SRSC). The scheduler drains the output and regenerates output TLAST.
- Sits between the AXI4-Stream slave port and the datapath. It gates S_AXIS_TREADY, steers pixels to the active pass, counts input and output beats, and flags framing errors.

Parameters:
- IMG_WIDTH, 512, pixels per line
- IMG_HEIGHT, 512, lines per frame
- CNT_W, 19, pixel counter width; must satisfy 2^CNT_W > IMG_WIDTH*IMG_HEIGHT
- DRAIN_TIMEOUT, 4096, maximum cycles in DRAIN with no output beat before a timeout error

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- enable  in  1  run enable; frames start only while high
- S_AXIS_TVALID  in  1  upstream pixel valid
- S_AXIS_TLAST  in  1  upstream end-of-frame marker
- S_AXIS_TREADY  out  1  upstream ready, gated by this block
- dp_valid  out  1  pixel valid to the datapath (S_AXIS_TVALID & S_AXIS_TREADY)
- pass_sel  out  1  0 = pass 1 (ALE), 1 = pass 2 (TE/SRSC)
- ale_clear  out  1  one-cycle pulse resetting ALE accumulators at frame start
- ale_last  out  1  one-cycle pulse with the final pass-1 pixel
- ale_done  in  1  ALE result valid (level or pulse)
- out_valid  in  1  datapath output beat valid
- M_AXIS_TREADY  in  1  downstream ready (observed only)
- M_AXIS_TLAST  out  1  regenerated end-of-frame on the last output beat
- frame_done  out  1  one-cycle pulse when the frame completes
- busy  out  1  high in every state except IDLE
- err_tlast  out  1  sticky: TLAST early or missing
- err_timeout  out  1  sticky: drain timeout
- err_clear  in  1  clears both sticky errors

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset is asynchronous and may occur mid-frame. Recovery returns to IDLE with no partial pulses.
- Let N = IMG_WIDTH*IMG_HEIGHT. An input beat is S_AXIS_TVALID & S_AXIS_TREADY. An output beat is out_valid & M_AXIS_TREADY.
- States:
  - IDLE: TREADY=0. If enable=1, pulse ale_clear for 1 cycle and go to PASS1.
  - PASS1: TREADY=1, pass_sel=0. Count input beats in in_cnt. On beat N: assert ale_last combinationally with that beat, clear in_cnt, go to ALE_WAIT.
  - ALE_WAIT: TREADY=0. If ale_done=1, go to PASS2 on the next cycle. ale_done arriving in the same cycle as ale_last is ignored; it is sampled from ALE_WAIT only.
  - PASS2: TREADY=1, pass_sel=1. Count input beats. On beat N, go to DRAIN. Output beats are counted in out_cnt from PASS2 onward.
  - DRAIN: TREADY=0. Wait until out_cnt reaches N.
  - DONE: pulse frame_done for 1 cycle. If enable=1, go to PASS1 with ale_clear; otherwise go to IDLE.
- TLAST checks:
  - TLAST on an input beat with in_cnt < N-1 sets err_tlast. The frame continues; counting is authoritative.
  - TLAST absent on beat N also sets err_tlast.
  - Checks apply in both passes.
- M_AXIS_TLAST = 1 only on the output beat where out_cnt == N-1.
- Output beats arriving in states other than PASS2/DRAIN are not counted.
- Timeout: in DRAIN, a counter increments each cycle without an output beat and resets on a beat. Reaching DRAIN_TIMEOUT sets err_timeout and forces DONE.
- Error clearing: err_clear has priority over a same-cycle error set; the error is dropped.
- enable deasserted mid-frame: the current frame completes and no new frame starts.
- Counters never wrap; compares use ==N-1 on CNT_W bits.
- Latency: ale_last is combinational with the accepting beat. frame_done comes 1 cycle after the Nth output beat.

Decomposition:
- Shared package haze_pkg: state encoding (IDLE, PASS1, ALE_WAIT, PASS2, DRAIN, DONE) and the N/CNT_W constants for the default image size.
- One sub-module, haze_beat_counter: a CNT_W counter with inc, clr and terminal-count (==N-1) output. It is instantiated twice, for in_cnt and out_cnt.

Test Plan:
- Nominal 4x4 frame (N=16), continuous valid, ale_done 5 cycles after ale_last: exactly 16 beats per pass, ale_last on beat 16 of pass 1, TREADY=0 for the 5 wait cycles, M_AXIS_TLAST on output beat 16, then a single frame_done.
- Random TVALID gaps (50%) and M_AXIS_TREADY backpressure: beat counts still 16/16/16, and no TLAST or frame_done glitches.
- TLAST on beat 10 of pass 1: err_tlast=1; pass 1 still ends at beat 16; err_clear drops it to 0 the next cycle.
- out_valid stopped at 12 beats with DRAIN_TIMEOUT=32: err_timeout=1 after 32 idle cycles, then frame_done, then IDLE if enable=0.
- ARESET asserted mid-PASS2: all outputs 0 immediately, and a subsequent frame runs cleanly with a fresh ale_clear.
- enable held high: two back-to-back frames run, with ale_clear at the start of each and no idle cycle between DONE and PASS1.
